// File: rtl/decode_packet_pkg.sv
// Shared definitions for the Aurora packet link (encode and decode sides).
// Holds the flit geometry, header field offsets, the receiver state encoding
// and the packed flit header layout.
package decode_packet_pkg;

    localparam int unsigned DATA_WIDTH        = 1024;
    localparam int unsigned ADDR_WIDTH        = 10;
    localparam int unsigned DATA_DFX_WIDTH    = DATA_WIDTH + ADDR_WIDTH;
    localparam int unsigned NUMBER_PACKET     = 19;
    localparam int unsigned FLIT_PAYLOAD      = 55;
    localparam int unsigned AURORA_DATA_WIDTH = 64;

    localparam int unsigned SRC_LSB        = 0;
    localparam int unsigned NUM_LSB        = 2;
    localparam int unsigned TTL_LSB        = 7;
    localparam int unsigned PAYLOAD_LSB    = 9;
    localparam int unsigned LAST_FLIT_BITS = 44;

    localparam int unsigned SRC_W = 2;
    localparam int unsigned NUM_W = 5;
    localparam int unsigned TTL_W = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        OUTPUT  = 2'd2
    } state_e;

    // Header bits [8:0] of a flit, MSB first.
    typedef struct packed {
        logic [TTL_W-1:0] ttl;
        logic [NUM_W-1:0] num;
        logic [SRC_W-1:0] src;
    } flit_hdr_t;

endpackage

// File: rtl/decode_packet_flit_unpack.sv
// flit_field_unpack: combinational split of one 64-bit Aurora flit.
// Ports:
//   flit_i     - raw flit
//   hdr_c      - src / packet number / TTL header fields
//   payload_c  - flit bits [63:9]
module flit_field_unpack
    import decode_packet_pkg::*;
(
    input  logic [AURORA_DATA_WIDTH-1:0] flit_i,
    output flit_hdr_t                    hdr_c,
    output logic [FLIT_PAYLOAD-1:0]      payload_c
);

    assign hdr_c.src = flit_i[SRC_LSB +: SRC_W];
    assign hdr_c.num = flit_i[NUM_LSB +: NUM_W];
    assign hdr_c.ttl = flit_i[TTL_LSB +: TTL_W];
    assign payload_c = flit_i[PAYLOAD_LSB +: FLIT_PAYLOAD];

endmodule

// File: rtl/decode_packet.sv
// decode_packet: Aurora RX reassembly. Checks flit sequence numbers and source,
// rebuilds the 1034-bit DFX word from 19 flits and hands it to the router
// controller over valid/ready.
// Ports:
//   clk, rst                - clock, synchronous active-high reset
//   fifo_valid_i/ready_o    - flit handshake from the RX FIFO
//   data_recv               - 64-bit flit
//   decode_valid_o/ready_i  - packet handshake to the router controller
//   data_decode_o           - payload, dfx[1033:10]
//   router_dst_addr_recv    - destination address, dfx[9:0]
//   src_router_o, ttl_o     - source router and TTL of the packet
//   decode_err_o            - one-cycle pulse on sequence/source error
// Build option: DECODE_TTL_CHECK_EN drops packets whose flit 0 carries TTL 0
// and reports TTL-1 for accepted packets.
module decode_packet
    import decode_packet_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         fifo_valid_i,
    output logic                         fifo_ready_o,
    input  logic [AURORA_DATA_WIDTH-1:0] data_recv,
    output logic                         decode_valid_o,
    input  logic                         decode_ready_i,
    output logic [DATA_WIDTH-1:0]        data_decode_o,
    output logic [ADDR_WIDTH-1:0]        router_dst_addr_recv,
    output logic [SRC_W-1:0]             src_router_o,
    output logic [TTL_W-1:0]             ttl_o,
    output logic                         decode_err_o
);

    localparam logic [NUM_W-1:0] LAST_NUM = NUM_W'(NUMBER_PACKET - 1);

    state_e                    state_q, state_d;
    logic [NUM_W-1:0]          exp_q, exp_d;
    logic [SRC_W-1:0]          src_q, src_d;
    logic [TTL_W-1:0]          ttl_q, ttl_d;
    logic [DATA_DFX_WIDTH-1:0] dfx_q, dfx_d;
    logic                      fifo_ready_q, fifo_ready_d;
    logic                      decode_valid_q, decode_valid_d;
    logic                      decode_err_q, decode_err_d;
`ifdef DECODE_TTL_CHECK_EN
    logic                      drop_q, drop_d;
`endif

    flit_hdr_t                 hdr_c;
    logic [FLIT_PAYLOAD-1:0]   payload_c;
    logic                      accept_c;
    logic                      start_c;
    logic                      store_c;

    flit_field_unpack u_unpack (
        .flit_i    (data_recv),
        .hdr_c     (hdr_c),
        .payload_c (payload_c)
    );

    assign accept_c = fifo_valid_i & fifo_ready_q;

    // Next-state, assembly and registered-output logic.
    always_comb begin
        state_d      = state_q;
        exp_d        = exp_q;
        src_d        = src_q;
        ttl_d        = ttl_q;
        dfx_d        = dfx_q;
        decode_err_d = 1'b0;
        start_c      = 1'b0;
        store_c      = 1'b0;
`ifdef DECODE_TTL_CHECK_EN
        drop_d       = drop_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (accept_c) begin
                    if (hdr_c.num == '0) begin
                        start_c = 1'b1;
                    end else begin
`ifdef DECODE_TTL_CHECK_EN
                        // Tail of a TTL-dropped packet is discarded silently.
                        decode_err_d = ~drop_q;
`else
                        decode_err_d = 1'b1;
`endif
                    end
                end
            end
            COLLECT: begin
                if (accept_c) begin
                    if (hdr_c.num == exp_q && hdr_c.src == src_q) begin
                        store_c = 1'b1;
                        exp_d   = NUM_W'(exp_q + NUM_W'(1));
                        if (hdr_c.num == LAST_NUM) begin
                            state_d = OUTPUT;
                        end
                    end else if (hdr_c.num == '0) begin
                        // A fresh flit 0 aborts the partial packet and restarts.
                        decode_err_d = 1'b1;
                        start_c      = 1'b1;
                    end else begin
                        decode_err_d = 1'b1;
                        dfx_d        = '0;
                        exp_d        = '0;
                        state_d      = IDLE;
                    end
                end
            end
            OUTPUT: begin
                if (decode_valid_q && decode_ready_i) begin
                    exp_d   = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                exp_d   = '0;
                state_d = IDLE;
            end
        endcase

        if (start_c) begin
            dfx_d   = '0;
            src_d   = hdr_c.src;
            exp_d   = NUM_W'(1);
            store_c = 1'b1;
            state_d = COLLECT;
`ifdef DECODE_TTL_CHECK_EN
            ttl_d  = TTL_W'(hdr_c.ttl - TTL_W'(1));
            drop_d = 1'b0;
            if (hdr_c.ttl == '0) begin
                decode_err_d = 1'b1;
                drop_d       = 1'b1;
                store_c      = 1'b0;
                exp_d        = '0;
                state_d      = IDLE;
            end
`else
            ttl_d = hdr_c.ttl;
`endif
        end

        // Flits 0..17 carry 55 payload bits each; flit 18 carries the top 44.
        if (store_c) begin
            for (int unsigned k = 0; k < NUMBER_PACKET - 1; k++) begin
                if (hdr_c.num == NUM_W'(k)) begin
                    dfx_d[k*FLIT_PAYLOAD +: FLIT_PAYLOAD] = payload_c;
                end
            end
            if (hdr_c.num == LAST_NUM) begin
                dfx_d[DATA_DFX_WIDTH-1 -: LAST_FLIT_BITS] = payload_c[LAST_FLIT_BITS-1:0];
            end
        end

        fifo_ready_d   = (state_d != OUTPUT);
        decode_valid_d = (state_d == OUTPUT);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            exp_q          <= '0;
            src_q          <= '0;
            ttl_q          <= '0;
            dfx_q          <= '0;
            fifo_ready_q   <= 1'b0;
            decode_valid_q <= 1'b0;
            decode_err_q   <= 1'b0;
`ifdef DECODE_TTL_CHECK_EN
            drop_q         <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            exp_q          <= exp_d;
            src_q          <= src_d;
            ttl_q          <= ttl_d;
            dfx_q          <= dfx_d;
            fifo_ready_q   <= fifo_ready_d;
            decode_valid_q <= decode_valid_d;
            decode_err_q   <= decode_err_d;
`ifdef DECODE_TTL_CHECK_EN
            drop_q         <= drop_d;
`endif
        end
    end

    assign fifo_ready_o         = fifo_ready_q;
    assign decode_valid_o       = decode_valid_q;
    assign decode_err_o         = decode_err_q;
    assign data_decode_o        = dfx_q[DATA_DFX_WIDTH-1:ADDR_WIDTH];
    assign router_dst_addr_recv = dfx_q[ADDR_WIDTH-1:0];
    assign src_router_o         = src_q;
    assign ttl_o                = ttl_q;

endmodule

// File: tb/tb_decode_packet.sv
// Self-checking bench for decode_packet: packets are built from a DFX word by
// the flit format rules, sent through the FIFO handshake and the reassembled
// outputs compared against the source word.
module tb_decode_packet;

    logic          clk;
    logic          rst;
    logic          fifo_valid_i;
    logic          fifo_ready_o;
    logic [63:0]   data_recv;
    logic          decode_valid_o;
    logic          decode_ready_i;
    logic [1023:0] data_decode_o;
    logic [9:0]    router_dst_addr_recv;
    logic [1:0]    src_router_o;
    logic [1:0]    ttl_o;
    logic          decode_err_o;

    int checks  = 0;
    int errors  = 0;
    int err_seen = 0;
    int hs_seen  = 0;
    int exp_err  = 0;
    int exp_hs   = 0;

    logic [63:0]   flits [19];
    logic [1033:0] word;

    decode_packet dut (
        .clk                  (clk),
        .rst                  (rst),
        .fifo_valid_i         (fifo_valid_i),
        .fifo_ready_o         (fifo_ready_o),
        .data_recv            (data_recv),
        .decode_valid_o       (decode_valid_o),
        .decode_ready_i       (decode_ready_i),
        .data_decode_o        (data_decode_o),
        .router_dst_addr_recv (router_dst_addr_recv),
        .src_router_o         (src_router_o),
        .ttl_o                (ttl_o),
        .decode_err_o         (decode_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts error pulses and packet handshakes as the link sees them.
    always @(posedge clk) begin
        err_seen <= err_seen + int'(decode_err_o);
        hs_seen  <= hs_seen + int'(decode_valid_o & decode_ready_i);
    end

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] ttl_exp(input logic [1:0] t);
`ifdef DECODE_TTL_CHECK_EN
        return 2'(t - 2'd1);
`else
        return t;
`endif
    endfunction

    function automatic logic [1033:0] rand_word();
        logic [1055:0] r;
        for (int i = 0; i < 33; i++) r[i*32 +: 32] = $urandom;
        return r[1033:0];
    endfunction

    function automatic logic [1033:0] ramp_word();
        logic [1039:0] r;
        for (int i = 0; i < 130; i++) r[i*8 +: 8] = 8'(i);
        return r[1033:0];
    endfunction

    // Encoder model: slices the DFX word into 19 flits with header fields.
    task automatic build(input logic [1033:0] w, input logic [1:0] s, input logic [1:0] t);
        logic [54:0] pl;
        for (int k = 0; k < 19; k++) begin
            if (k < 18) pl = w[k*55 +: 55];
            else        pl = {11'($urandom), w[1033:990]};
            flits[k] = {pl, t, 5'(k), s};
        end
        word = w;
    endtask

    // Called at a negedge; returns at the negedge after the flit is consumed.
    task automatic send_flit(input logic [63:0] f);
        int n = 0;
        fifo_valid_i = 1'b1;
        data_recv    = f;
        while (!fifo_ready_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("fifo_ready_wait", 64'(fifo_ready_o), 64'd1);
        @(negedge clk);
        fifo_valid_i = 1'b0;
    endtask

    task automatic send_range(input int lo, input int hi, input int max_gap);
        for (int k = lo; k <= hi; k++) begin
            repeat ($urandom_range(0, max_gap)) @(negedge clk);
            send_flit(flits[k]);
        end
    endtask

    task automatic expect_out(input string tag, input logic [1:0] s, input logic [1:0] t);
        logic [1087:0] e;
        logic [1087:0] g;
        e = 1088'(word);
        g = 1088'({data_decode_o, router_dst_addr_recv});
        check({tag, "_valid"}, 64'(decode_valid_o), 64'd1);
        check({tag, "_fifo_rdy"}, 64'(fifo_ready_o), 64'd0);
        for (int i = 0; i < 17; i++)
            check($sformatf("%s_dfx%0d", tag, i), g[i*64 +: 64], e[i*64 +: 64]);
        check({tag, "_src"}, 64'(src_router_o), 64'(s));
        check({tag, "_ttl"}, 64'(ttl_o), 64'(ttl_exp(t)));
    endtask

    task automatic check_counts(input string tag);
        @(negedge clk);
        check({tag, "_err_cnt"}, 64'(err_seen), 64'(exp_err));
        check({tag, "_hs_cnt"}, 64'(hs_seen), 64'(exp_hs));
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_fifo_rdy"}, 64'(fifo_ready_o), 64'd0);
        check({tag, "_valid"}, 64'(decode_valid_o), 64'd0);
        check({tag, "_err"}, 64'(decode_err_o), 64'd0);
        check({tag, "_src"}, 64'(src_router_o), 64'd0);
        check({tag, "_ttl"}, 64'(ttl_o), 64'd0);
        check({tag, "_data_lo"}, data_decode_o[63:0], 64'd0);
        check({tag, "_addr"}, 64'(router_dst_addr_recv), 64'd0);
    endtask

    // Full clean packet with ready high: valid one cycle after flit 18, gone one later.
    task automatic clean_packet(input string tag, input logic [1:0] s, input logic [1:0] t);
        build(rand_word(), s, t);
        decode_ready_i = 1'b1;
        send_range(0, 18, 0);
        expect_out(tag, s, t);
        exp_hs++;
        @(negedge clk);
        check({tag, "_valid_clr"}, 64'(decode_valid_o), 64'd0);
        check({tag, "_fifo_rdy_back"}, 64'(fifo_ready_o), 64'd1);
    endtask

    initial begin
        logic [63:0] f;
        logic [1:0]  s;
        logic [1:0]  t;
        int          d;

        rst            = 1'b1;
        fifo_valid_i   = 1'b0;
        data_recv      = '0;
        decode_ready_i = 1'b1;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;

        // Ramp packet, src 2, TTL 3, ready high.
        build(ramp_word(), 2'd2, 2'd3);
        send_range(0, 18, 0);
        expect_out("ramp", 2'd2, 2'd3);
        exp_hs++;
        @(negedge clk);
        check("ramp_valid_clr", 64'(decode_valid_o), 64'd0);
        check("ramp_fifo_rdy", 64'(fifo_ready_o), 64'd1);
        check_counts("ramp");

        // Backpressure: ready low for 5 cycles with a flit waiting in the FIFO.
        build(rand_word(), 2'd1, 2'd2);
        decode_ready_i = 1'b0;
        send_range(0, 18, 1);
        fifo_valid_i = 1'b1;
        data_recv    = flits[0];
        for (int c = 0; c < 5; c++) begin
            expect_out($sformatf("bp%0d", c), 2'd1, 2'd2);
            @(negedge clk);
        end
        decode_ready_i = 1'b1;
        fifo_valid_i   = 1'b0;
        exp_hs++;
        @(negedge clk);
        check("bp_valid_clr", 64'(decode_valid_o), 64'd0);
        check("bp_fifo_rdy", 64'(fifo_ready_o), 64'd1);
        check_counts("bp");

        // Sequence gap: flits 0..6 then a flit numbered 9.
        build(rand_word(), 2'd3, 2'd1);
        send_range(0, 6, 0);
        f = flits[7];
        f[6:2] = 5'd9;
        send_flit(f);
        exp_err++;
        check("gap_err", 64'(decode_err_o), 64'd1);
        check("gap_valid", 64'(decode_valid_o), 64'd0);
        @(negedge clk);
        check("gap_err_pulse", 64'(decode_err_o), 64'd0);
        check("gap_fifo_rdy", 64'(fifo_ready_o), 64'd1);
        clean_packet("after_gap", 2'd0, 2'd2);
        check_counts("gap");

        // Source mismatch mid-packet.
        build(rand_word(), 2'd1, 2'd1);
        send_range(0, 3, 0);
        f = flits[4];
        f[1:0] = f[1:0] ^ 2'b10;
        send_flit(f);
        exp_err++;
        check("src_err", 64'(decode_err_o), 64'd1);
        check_counts("src");

        // Nonzero flit while idle.
        build(rand_word(), 2'd2, 2'd1);
        send_flit(flits[5]);
        exp_err++;
        check("idle_err", 64'(decode_err_o), 64'd1);
        check_counts("idle");

        // Restart: flits 0..10, then a new packet from flit 0 with a new source.
        build(rand_word(), 2'd1, 2'd3);
        send_range(0, 10, 0);
        build(rand_word(), 2'd2, 2'd1);
        send_flit(flits[0]);
        exp_err++;
        check("restart_err", 64'(decode_err_o), 64'd1);
        send_range(1, 18, 0);
        expect_out("restart", 2'd2, 2'd1);
        exp_hs++;
        check_counts("restart");

        // Reset while flit 12 is offered.
        build(rand_word(), 2'd3, 2'd3);
        send_range(0, 11, 0);
        fifo_valid_i = 1'b1;
        data_recv    = flits[12];
        rst          = 1'b1;
        @(negedge clk);
        check_zero("midrst");
        rst          = 1'b0;
        fifo_valid_i = 1'b0;
        clean_packet("after_rst", 2'd3, 2'd2);
        check_counts("midrst");

        // TTL of zero on flit 0.
`ifdef DECODE_TTL_CHECK_EN
        build(rand_word(), 2'd1, 2'd0);
        send_flit(flits[0]);
        exp_err++;
        check("ttl0_err", 64'(decode_err_o), 64'd1);
        check("ttl0_valid", 64'(decode_valid_o), 64'd0);
        @(negedge clk);
        clean_packet("ttl2", 2'd1, 2'd2);
        check("ttl2_ttl_dec", 64'(ttl_o), 64'd1);
`else
        clean_packet("ttl0", 2'd1, 2'd0);
`endif
        check_counts("ttl");

        // Random packets with flit gaps and random consumer delay.
        for (int p = 0; p < 4; p++) begin
            s = 2'($urandom_range(0, 3));
            t = 2'($urandom_range(1, 3));
            d = int'($urandom_range(0, 3));
            build(rand_word(), s, t);
            decode_ready_i = 1'b0;
            send_range(0, 18, 2);
            expect_out($sformatf("rnd%0d", p), s, t);
            repeat (d) @(negedge clk);
            check($sformatf("rnd%0d_hold", p), 64'(decode_valid_o), 64'd1);
            decode_ready_i = 1'b1;
            exp_hs++;
            @(negedge clk);
            check($sformatf("rnd%0d_valid_clr", p), 64'(decode_valid_o), 64'd0);
        end
        check_counts("rnd");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
